// File: rtl/stream_deserializer.sv
// Beat-to-word deserializer: packs Ratio narrow beats into one wide word.
// A beat flagged last closes the word early; keep marks the filled slots.
module stream_deserializer #(
    parameter int InWidth = 8,
    parameter int Ratio   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [InWidth-1:0]         in_data_i,
    input  logic                       in_last_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [InWidth*Ratio-1:0]   out_data_o,
    output logic [Ratio-1:0]           out_keep_o,
    output logic                       out_last_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i
);

    localparam int OutWidth = InWidth * Ratio;
    localparam int CntWidth = (Ratio > 1) ? $clog2(Ratio) : 1;

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t              state;
    logic [CntWidth-1:0] cnt;
    logic                beat;
    logic                word;
    logic                last_slot;

    assign out_valid_o = (state == FULL);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign beat        = in_valid_i && in_ready_o;
    assign word        = out_valid_o && out_ready_i;
    assign last_slot   = (cnt == CntWidth'(Ratio - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= COLLECT;
            cnt        <= '0;
            out_data_o <= '0;
            out_keep_o <= '0;
            out_last_o <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (beat) begin
                        for (int k = 0; k < Ratio; k++) begin
                            if (cnt == CntWidth'(k)) begin
                                out_data_o[k*InWidth +: InWidth] <= in_data_i;
                                out_keep_o[k]                    <= 1'b1;
                            end
                        end
                        if (last_slot || in_last_i) begin
                            state      <= FULL;
                            out_last_o <= in_last_i;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (word && beat) begin
                        // retiring word frees the register; new beat opens slot 0
                        out_data_o <= OutWidth'(in_data_i);
                        out_keep_o <= Ratio'(1'b1);
                        if (Ratio == 1 || in_last_i) begin
                            out_last_o <= in_last_i;
                            cnt        <= '0;
                        end else begin
                            state      <= COLLECT;
                            out_last_o <= 1'b0;
                            cnt        <= CntWidth'(1);
                        end
                    end else if (word) begin
                        state      <= COLLECT;
                        out_data_o <= '0;
                        out_keep_o <= '0;
                        out_last_o <= 1'b0;
                        cnt        <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
